// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv_enc_pkg
//  Description : Shared types and constants for the RV32I instruction encoder:
//                op-class enum, base opcodes, fixed funct3 values and the
//                encoder FSM state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package rv_enc_pkg;

    // Symbolic op classes carried by an input descriptor; codes 6 and 7 are
    // undefined and cause the descriptor to be rejected.
    typedef enum logic [2:0] {
        OP_LW    = 3'd0,
        OP_SW    = 3'd1,
        OP_RTYPE = 3'd2,
        OP_BEQ   = 3'd3,
        OP_ITYPE = 3'd4,
        OP_JAL   = 3'd5
    } opclass_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } enc_state_e;

endpackage : rv_enc_pkg
`default_nettype wire

// File: rtl/instr_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fmt
//  Description : Purely combinational RV32I field packer. Packs one symbolic
//                descriptor into a 32-bit instruction word and flags whether
//                the op class is defined and the immediate is acceptable.
//  Ports       : op/rd/rs1/rs2/funct3/funct7b5/imm  descriptor fields (in)
//                instr      packed instruction word                  (out)
//                op_valid   op class is one of the six defined codes (out)
//                valid_imm  immediate acceptable for the format      (out)
//  Config      : INSTR_ENC_IMM_CHECK_EN enables immediate range checking;
//                without it immediates are silently truncated.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fmt
    import rv_enc_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        op_valid,
    output logic        valid_imm
);

    logic fit_i;
    logic fit_b;
    logic fit_j;

`ifdef INSTR_ENC_IMM_CHECK_EN
    // B and J offsets must be even: bit 0 is not representable.
    assign fit_i = ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
    assign fit_b = ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && !imm[0];
    assign fit_j = ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && !imm[0];
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
    assign fit_i = 1'b1;
    assign fit_b = 1'b1;
    assign fit_j = 1'b1;
`endif

    always_comb begin
        instr     = 32'd0;
        op_valid  = 1'b1;
        valid_imm = 1'b1;
        case (op)
            OP_LW: begin
                instr     = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
                valid_imm = fit_i;
            end
            OP_SW: begin
                instr     = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
                valid_imm = fit_i;
            end
            OP_RTYPE: begin
                instr = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
            end
            OP_BEQ: begin
                instr     = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
                valid_imm = fit_b;
            end
            OP_ITYPE: begin
                instr     = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
                valid_imm = fit_i;
            end
            OP_JAL: begin
                instr     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                valid_imm = fit_j;
            end
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

endmodule : instr_fmt
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streaming RV32I instruction encoder. Accepts symbolic
//                descriptors over valid/ready, emits packed instruction words
//                with their word addresses through a single output register.
//  Ports       : clk, reset_n (sync, active low), start
//                in_valid/in_ready/in_last + descriptor fields
//                out_valid/out_ready, out_instr, out_addr
//                done  one-cycle pulse when the program has fully drained
//                err   one-cycle pulse when an accepted descriptor is rejected
//  Config      : INSTR_ENC_IMM_CHECK_EN (see instr_fmt) rejects out-of-range
//                immediates.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err
);
    import rv_enc_pkg::*;

    enc_state_e        state;
    enc_state_e        state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       fmt_instr;
    logic              fmt_op_ok;
    logic              fmt_imm_ok;
    logic              accept;
    logic              good;
    logic              out_hs;

    instr_fmt u_fmt (
        .op        (in_op),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7b5  (in_funct7b5),
        .imm       (in_imm),
        .instr     (fmt_instr),
        .op_valid  (fmt_op_ok),
        .valid_imm (fmt_imm_ok)
    );

    assign accept = in_valid && in_ready;
    assign good   = accept && fmt_op_ok && fmt_imm_ok;
    assign err    = accept && !(fmt_op_ok && fmt_imm_ok);
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                in_ready = !out_valid || out_ready;
                // Last descriptor ends the program whether or not it was encodable.
                if (in_valid && (!out_valid || out_ready) && in_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Either the final word leaves now, or nothing is held
                // (last descriptor rejected): the program is complete.
                if (!out_valid || out_ready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= '0;
            addr_cnt  <= '0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE && start) begin
                addr_cnt <= ADDR_W'(BASE_ADDR);
            end else if (out_hs) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            // A new word can only be captured when the register is empty or
            // draining this cycle; in the latter case it takes the next address.
            if (good) begin
                out_valid <= 1'b1;
                out_instr <= fmt_instr;
                out_addr  <= out_hs ? addr_cnt + ADDR_W'(1) : addr_cnt;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule : instr_encoder
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the controller's main decoder. It accepts symbolic instruction descriptors (op class, register indices, funct fields, immediate) over a valid/ready handshake. For each descriptor it emits a packed 32-bit instruction word plus a word address through one output register. It sits between the test/boot program source and instruction-memory write port, loading programs into the single-cycle core.

## Interface
- `ADDR_W`, 10: width of word-address counter.
- `BASE_ADDR`, 0: word address loaded on `start`.
- `clk`  in  1  clock, all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a program load; honoured only in IDLE.
- `in_valid`  in  1  descriptor valid.
- `in_ready`  out  1  descriptor accepted when `in_valid && in_ready`.
- `in_last`  in  1  marks final descriptor of the program.
- `in_op`  in  3  op class (`opclass_e`): LW, SW, RTYPE, BEQ, ITYPE, JAL.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  used by RTYPE/ITYPE only.
- `in_funct7b5`  in  1  RTYPE funct7[5] (add/sub).
- `in_imm`  in  32  signed byte immediate/offset.
- `out_valid`  out  1  `out_instr`/`out_addr` valid.
- `out_ready`  in  1  sink accepts when `out_valid && out_ready`.
- `out_instr`  out  32  encoded instruction.
- `out_addr`  out  ADDR_W  word address of `out_instr`.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `err`  out  1  one-cycle pulse when a descriptor is rejected.

## Operation
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE: `in_ready=0`. `start` loads the address counter with `BASE_ADDR` and moves to ACTIVE.
  - ACTIVE: `in_ready = !out_valid || out_ready`. An accepted descriptor with `in_last=1` moves to DRAIN, including when that descriptor is rejected.
  - DRAIN: `in_ready=0`. On the output handshake of the last word, `done=1` and the FSM goes to IDLE. If the last descriptor was rejected, `done` pulses the cycle after acceptance.
- `start` outside IDLE is ignored.
- Encoding, opcode/funct3 per class:
  - LW: 0000011 / 010, I-format.
  - SW: 0100011 / 010, S-format.
  - RTYPE: 0110011 / `in_funct3`, funct7=`{0,in_funct7b5,00000}`.
  - BEQ: 1100011 / 000, B-format.
  - ITYPE: 0010011 / `in_funct3`, I-format.
  - JAL: 1101111, J-format.
- Fields not used by a format are ignored.
- Undefined `in_op` codes: descriptor consumed, `err` pulses, nothing emitted.
- Address: `out_addr` is captured with the word. The counter increments by 1 on each output handshake and wraps modulo 2^ADDR_W silently.
- Rejected descriptors do not advance the address.

## Timing
- Latency: word is registered, so `out_valid` rises 1 cycle after input acceptance.
- Full throughput (1 word/cycle) when `out_ready=1`.
- While `out_valid && !out_ready`: `out_instr`/`out_addr` are held stable and `in_ready=0`.
- Simultaneous input and output handshake in the same cycle: the new word replaces the old one, and the counter increments once.
- `err` pulses in the acceptance cycle, combinational from the accepted descriptor.
- Reset values: FSM=IDLE, `out_valid=0`, `out_instr=0`, `out_addr=0`, counter=0, `done=0`, `err=0`, `in_ready=0`.
- Reset in any state, including mid-DRAIN with a held word, discards the word with no `done`.

## Configuration
- `INSTR_ENC_IMM_CHECK_EN` defined: immediate range check. Rejected (`err`, no word, no address advance) when:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or odd.
  - J: imm outside [-2^20, 2^20-2] or odd.
- Undefined: immediates are truncated to the format width (bit 0 dropped for B/J). Only undefined `in_op` codes raise `err`.

## Structure
- Package `rv_enc_pkg`:
  - `opclass_e` enum.
  - Opcode constants OPC_LOAD, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_OPIMM, OPC_JAL.
  - funct3 constants F3_LW, F3_SW, F3_BEQ.
  - FSM state enum.
- Sub-module `instr_fmt`: purely combinational field packer/range checker (descriptor in, `{instr, valid_imm}` out). `instr_encoder` holds the FSM, output register and address counter.

## Test plan
- start, LW rd=5 rs1=2 imm=8 (last) -> `out_instr=0x00812283`, `out_addr=0`. `done` pulses on the handshake.
- Back-to-back burst, BASE_ADDR=4, `out_ready=1`:
  - SW rs2=5 rs1=2 imm=12 -> `0x00512623` @4.
  - RTYPE rd=3 rs1=1 rs2=2 f3=0 b5=0 -> `0x002081B3` @5.
  - Same with b5=1 -> `0x402081B3` @6.
  - JAL rd=1 imm=8 -> `0x008000EF` @7.
- `out_ready=0` for 3 cycles mid-burst -> word and address stable, `in_ready=0`, no descriptor lost. Resumes at the next address.
- With IMM_CHECK_EN: ITYPE imm=2048 and BEQ imm=3 -> `err` pulse each, no word, address unchanged. Without the macro: ITYPE imm=2048 emits imm field 0x800.
- ADDR_W=2, BASE_ADDR=3, two words -> addresses 3 then 0.
- `reset_n=0` during DRAIN with a held word -> `out_valid=0`, IDLE, no `done`. A subsequent `start` restarts at BASE_ADDR.
